// File: rtl/syscall_unit.sv
// syscall_unit: services the syscall strobe of the single-cycle core.
// When syscall is seen in IDLE the core is frozen (stall), $v0/$a0 are
// latched, and the requested service runs: print signed int, print a
// null-terminated string read byte-by-byte from memory, print a char, or
// exit (halt). Console bytes leave over a tx_valid/tx_ready handshake.
// After a service the core is released for exactly one cycle (DONE) so the
// PC steps past the syscall instruction.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   syscall, v0, a0     strobe from control unit, register file $2 / $4
//   stall               freeze PC and register/memory writes (combinational)
//   halt                sticky halt from the exit service
//   err                 one-cycle pulse: unknown code or truncated string
//   mem_addr, mem_rd    byte read request; mem_rdata valid the next cycle
//   tx_data, tx_valid   console byte stream, accepted when tx_ready is high
module syscall_unit #(
    parameter int CODE_PRINT_INT  = 1,
    parameter int CODE_PRINT_STR  = 4,
    parameter int CODE_EXIT       = 10,
    parameter int CODE_PRINT_CHAR = 11,
    parameter int MAX_STR         = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        syscall,
    input  logic [31:0] v0,
    input  logic [31:0] a0,
    output logic        stall,
    output logic        halt,
    output logic        err,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int CW = $clog2(MAX_STR + 1);

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_DISPATCH = 4'd1,
        ST_INT_SIGN = 4'd2,
        ST_INT_DIGIT= 4'd3,
        ST_STR_REQ  = 4'd4,
        ST_STR_WAIT = 4'd5,
        ST_EMIT     = 4'd6,
        ST_DONE     = 4'd7,
        ST_HALT     = 4'd8
    } state_t;

    state_t          state_r, state_next;
    state_t          ret_r, ret_next;        // state to resume after EMIT
    logic [31:0]     code_r, code_next;
    logic [31:0]     arg_r, arg_next;
    logic [31:0]     ptr_r, ptr_next;
    logic [CW-1:0]   count_r, count_next;
    logic [31:0]     mag_r, mag_next;
    logic [3:0]      p_r, p_next;            // current decimal power index
    logic [3:0]      digit_r, digit_next;
    logic            started_r, started_next; // a significant digit was printed
    logic            err_pend_r, err_pend_next; // raise err when EMIT returns
    logic [7:0]      tx_data_r, tx_data_next;
    logic            tx_valid_r, tx_valid_next;
    logic [31:0]     mem_addr_r, mem_addr_next;
    logic            mem_rd_r, mem_rd_next;
    logic            halt_r, halt_next;
    logic            err_r, err_next;

    // Powers of ten used by the repeated-subtraction digit extractor.
    function automatic logic [31:0] pow10(input logic [3:0] p);
        case (p)
            4'd0:    pow10 = 32'd1;
            4'd1:    pow10 = 32'd10;
            4'd2:    pow10 = 32'd100;
            4'd3:    pow10 = 32'd1000;
            4'd4:    pow10 = 32'd10000;
            4'd5:    pow10 = 32'd100000;
            4'd6:    pow10 = 32'd1000000;
            4'd7:    pow10 = 32'd10000000;
            4'd8:    pow10 = 32'd100000000;
            4'd9:    pow10 = 32'd1000000000;
            default: pow10 = 32'd1;
        endcase
    endfunction

    // The core must freeze in the very cycle the syscall is first decoded.
    assign stall = ((state_r == ST_IDLE) && syscall) ||
                   ((state_r != ST_IDLE) && (state_r != ST_DONE));

    assign halt     = halt_r;
    assign err      = err_r;
    assign mem_addr = mem_addr_r;
    assign mem_rd   = mem_rd_r;
    assign tx_data  = tx_data_r;
    assign tx_valid = tx_valid_r;

    // Next-state and next-output logic of the service sequencer.
    always_comb begin
        state_next    = state_r;
        ret_next      = ret_r;
        code_next     = code_r;
        arg_next      = arg_r;
        ptr_next      = ptr_r;
        count_next    = count_r;
        mag_next      = mag_r;
        p_next        = p_r;
        digit_next    = digit_r;
        started_next  = started_r;
        err_pend_next = err_pend_r;
        tx_data_next  = tx_data_r;
        tx_valid_next = tx_valid_r;
        err_next      = 1'b0;
        mem_addr_next = mem_addr_r;
        mem_rd_next   = 1'b0;
        halt_next     = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (syscall) begin
                    code_next  = v0;
                    arg_next   = a0;
                    state_next = ST_DISPATCH;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_DISPATCH: begin
                if (code_r == 32'(CODE_PRINT_INT)) begin
                    state_next = ST_INT_SIGN;
                end else if (code_r == 32'(CODE_PRINT_STR)) begin
                    ptr_next   = arg_r;
                    count_next = '0;
                    state_next = ST_STR_REQ;
                end else if (code_r == 32'(CODE_PRINT_CHAR)) begin
                    tx_data_next  = arg_r[7:0];
                    tx_valid_next = 1'b1;
                    ret_next      = ST_DONE;
                    state_next    = ST_EMIT;
                end else if (code_r == 32'(CODE_EXIT)) begin
                    state_next = ST_HALT;
                end else begin
                    err_next   = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_INT_SIGN: begin
                p_next       = 4'd9;
                started_next = 1'b0;
                digit_next   = 4'd0;
                if (arg_r[31]) begin
                    // Two's complement negate; 0x80000000 maps to 2^31 unsigned.
                    mag_next      = (~arg_r) + 32'd1;
                    tx_data_next  = 8'h2D;
                    tx_valid_next = 1'b1;
                    ret_next      = ST_INT_DIGIT;
                    state_next    = ST_EMIT;
                end else begin
                    mag_next   = arg_r;
                    state_next = ST_INT_DIGIT;
                end
            end
            ST_INT_DIGIT: begin
                if (mag_r >= pow10(p_r)) begin
                    mag_next   = mag_r - pow10(p_r);
                    digit_next = digit_r + 4'd1;
                end else begin
                    digit_next = 4'd0;
                    p_next     = p_r - 4'd1;
                    // Leading zeros are skipped; the units digit always prints.
                    if ((digit_r != 4'd0) || started_r || (p_r == 4'd0)) begin
                        tx_data_next  = 8'h30 + {4'h0, digit_r};
                        tx_valid_next = 1'b1;
                        started_next  = 1'b1;
                        ret_next      = (p_r == 4'd0) ? ST_DONE : ST_INT_DIGIT;
                        state_next    = ST_EMIT;
                    end else begin
                        state_next = ST_INT_DIGIT;
                    end
                end
            end
            ST_STR_REQ: begin
                state_next = ST_STR_WAIT;
            end
            ST_STR_WAIT: begin
                if (mem_rdata == 8'h00) begin
                    state_next = ST_DONE;
                end else begin
                    tx_data_next  = mem_rdata;
                    tx_valid_next = 1'b1;
                    ptr_next      = ptr_r + 32'd1;
                    count_next    = count_r + CW'(1);
                    state_next    = ST_EMIT;
                    if (count_r == CW'(MAX_STR - 1)) begin
                        ret_next      = ST_DONE;
                        err_pend_next = 1'b1;
                    end else begin
                        ret_next      = ST_STR_REQ;
                        err_pend_next = 1'b0;
                    end
                end
            end
            ST_EMIT: begin
                if (tx_valid_r && tx_ready) begin
                    tx_valid_next = 1'b0;
                    err_next      = err_pend_r;
                    err_pend_next = 1'b0;
                    state_next    = ret_r;
                end else begin
                    state_next = ST_EMIT;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Registered memory request and halt flag track the state being entered.
        mem_rd_next = (state_next == ST_STR_REQ);
        halt_next   = (state_next == ST_HALT);
        if (state_next == ST_STR_REQ) begin
            mem_addr_next = ptr_next;
        end else begin
            mem_addr_next = mem_addr_r;
        end
    end

    // State and output registers; reset aborts any service in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            ret_r      <= ST_IDLE;
            code_r     <= 32'd0;
            arg_r      <= 32'd0;
            ptr_r      <= 32'd0;
            count_r    <= '0;
            mag_r      <= 32'd0;
            p_r        <= 4'd0;
            digit_r    <= 4'd0;
            started_r  <= 1'b0;
            err_pend_r <= 1'b0;
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
            mem_addr_r <= 32'd0;
            mem_rd_r   <= 1'b0;
            halt_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_next;
            ret_r      <= ret_next;
            code_r     <= code_next;
            arg_r      <= arg_next;
            ptr_r      <= ptr_next;
            count_r    <= count_next;
            mag_r      <= mag_next;
            p_r        <= p_next;
            digit_r    <= digit_next;
            started_r  <= started_next;
            err_pend_r <= err_pend_next;
            tx_data_r  <= tx_data_next;
            tx_valid_r <= tx_valid_next;
            mem_addr_r <= mem_addr_next;
            mem_rd_r   <= mem_rd_next;
            halt_r     <= halt_next;
            err_r      <= err_next;
        end
    end

endmodule

// File: tb/tb_syscall_unit.sv
// Self-checking bench for syscall_unit: directed cases plus randomized
// services compared against a string/array level reference model.
module tb_syscall_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        syscall;
    logic [31:0] v0;
    logic [31:0] a0;
    logic        stall;
    logic        halt;
    logic        err;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    always #5 clk = ~clk;

    syscall_unit dut (
        .clk       (clk),
        .reset     (reset),
        .syscall   (syscall),
        .v0        (v0),
        .a0        (a0),
        .stall     (stall),
        .halt      (halt),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_rdata (mem_rdata),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    logic [7:0]  membuf [0:1023];
    int          ready_pct = 100;
    int          hold_cnt = 0;
    logic [7:0]  got_q[$];
    logic [31:0] rd_q[$];
    int          err_cnt = 0;
    int          stab_err = 0;
    logic        pend = 1'b0;
    logic [7:0]  pend_data = 8'h00;

    logic [7:0]  exp_q[$];
    logic [31:0] exp_rd[$];
    int          exp_err;
    int          svc_cycles;
    logic        svc_done;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory answers one cycle after a read request.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= membuf[mem_addr[9:0]];
    end

    // Console sink and bus monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            tx_ready = 1'b1;
            pend     = 1'b0;
        end else begin
            if (pend && (!tx_valid || tx_data !== pend_data)) stab_err++;
            if (tx_valid && hold_cnt > 0) begin
                tx_ready = 1'b0;
                hold_cnt--;
            end else begin
                tx_ready = ($urandom_range(99) < ready_pct);
            end
            if (tx_valid && tx_ready) got_q.push_back(tx_data);
            pend      = tx_valid && !tx_ready;
            pend_data = tx_data;
            if (err) err_cnt++;
            if (mem_rd) rd_q.push_back(mem_addr);
        end
    end

    // Reference: what the console, error line and memory port should show.
    task automatic build_model(input logic [31:0] code, input logic [31:0] arg);
        string s;
        int n;
        logic [31:0] a;
        exp_q.delete();
        exp_rd.delete();
        exp_err = 0;
        if (code == 32'd1) begin
            s = $sformatf("%0d", $signed(arg));
            for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        end else if (code == 32'd4) begin
            n = 0;
            while (n < 256) begin
                a = arg + 32'(n);
                exp_rd.push_back(a);
                if (membuf[a[9:0]] == 8'h00) break;
                exp_q.push_back(membuf[a[9:0]]);
                n++;
            end
            if (n == 256) exp_err = 1;
        end else if (code == 32'd11) begin
            exp_q.push_back(arg[7:0]);
        end else if (code != 32'd10) begin
            exp_err = 1;
        end
    endtask

    task automatic run_svc(input logic [31:0] code, input logic [31:0] arg, input int budget);
        got_q.delete();
        rd_q.delete();
        err_cnt  = 0;
        stab_err = 0;
        @(negedge clk);
        v0 = code;
        a0 = arg;
        syscall = 1'b1;
        #1 check_eq("stall_entry", {31'd0, stall}, 32'd1);
        svc_cycles = 0;
        svc_done   = 1'b0;
        while (!svc_done && svc_cycles < budget) begin
            @(negedge clk);
            svc_cycles++;
            #1;
            if (!stall) svc_done = 1'b1;
        end
        syscall = 1'b0;
        v0 = 32'd0;
        a0 = 32'd0;
        @(negedge clk);
        #1 check_eq("idle_stall", {31'd0, stall}, 32'd0);
        build_model(code, arg);
        check_eq($sformatf("svc_done code=%0d", code), {31'd0, svc_done}, 32'd1);
        check_eq($sformatf("tx_count code=%0d arg=%h", code, arg), got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_eq($sformatf("tx_byte[%0d]", i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
        check_eq("err_pulses", err_cnt, exp_err);
        check_eq("tx_stable", stab_err, 0);
        if (code == 32'd4) begin
            check_eq("rd_count", rd_q.size(), exp_rd.size());
            for (int i = 0; i < exp_rd.size() && i < rd_q.size(); i++)
                check_eq($sformatf("rd_addr[%0d]", i), rd_q[i], exp_rd[i]);
        end
    endtask

    initial begin
        int len;
        int sel;
        logic [31:0] code;
        logic [31:0] arg;
        reset = 1'b1;
        syscall = 1'b0;
        v0 = 32'd0;
        a0 = 32'd0;
        for (int i = 0; i < 1024; i++) membuf[i] = 8'h00;
        #2;
        check_eq("rst_stall", {31'd0, stall}, 32'd0);
        check_eq("rst_halt", {31'd0, halt}, 32'd0);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        check_eq("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check_eq("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        check_eq("rst_mem_addr", mem_addr, 32'd0);
        check_eq("rst_tx_data", {24'd0, tx_data}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Directed cases.
        run_svc(32'd11, 32'h41, 50);
        check_eq("char_cycles", svc_cycles, 3);
        run_svc(32'd1, 32'hFFFFFF85, 200);
        run_svc(32'd1, 32'h0, 200);
        run_svc(32'd1, 32'h80000000, 300);
        membuf[10'h100] = 8'h48;
        membuf[10'h101] = 8'h69;
        membuf[10'h102] = 8'h00;
        run_svc(32'd4, 32'h100, 200);
        hold_cnt = 5;
        run_svc(32'd11, 32'h7E, 100);
        check_eq("hold_cycles", svc_cycles, 8);
        run_svc(32'd7, 32'h0, 20);
        check_eq("bad_code_cycles", svc_cycles, 2);
        for (int i = 0; i < 300; i++) membuf[(32'h200 + i) % 1024] = 8'(1 + (i % 255));
        membuf[(32'h200 + 300) % 1024] = 8'h00;
        run_svc(32'd4, 32'h200, 5000);

        // Randomized services with a jittery console.
        for (int it = 0; it < 40; it++) begin
            ready_pct = $urandom_range(30, 100);
            sel = $urandom_range(0, 9);
            arg = $urandom;
            if (sel < 3) begin
                code = 32'd1;
                if (sel == 1) arg = 32'($urandom_range(0, 20));
                if (sel == 2) arg = -32'($urandom_range(1, 20));
            end else if (sel < 6) begin
                code = 32'd4;
                len = $urandom_range(0, 12);
                for (int i = 0; i < len; i++) membuf[10'(arg + 32'(i))] = 8'($urandom_range(1, 255));
                membuf[10'(arg + 32'(len))] = 8'h00;
            end else if (sel < 8) begin
                code = 32'd11;
            end else begin
                code = 32'($urandom_range(12, 300));
            end
            run_svc(code, arg, 2000);
        end
        ready_pct = 100;

        // Reset while a byte is waiting on the console.
        got_q.delete();
        hold_cnt = 1000;
        @(negedge clk);
        v0 = 32'd11;
        a0 = 32'h5A;
        syscall = 1'b1;
        for (int i = 0; i < 10 && !tx_valid; i++) @(negedge clk);
        check_eq("rst_mid_valid_seen", {31'd0, tx_valid}, 32'd1);
        syscall = 1'b0;
        #1 reset = 1'b1;
        #1;
        check_eq("rst_mid_tx_valid", {31'd0, tx_valid}, 32'd0);
        check_eq("rst_mid_stall", {31'd0, stall}, 32'd0);
        hold_cnt = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_mid_no_tx", got_q.size(), 0);
        run_svc(32'd11, 32'h33, 50);

        // Exit service, then a syscall that must be ignored, then reset.
        got_q.delete();
        @(negedge clk);
        v0 = 32'd10;
        a0 = 32'd0;
        syscall = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check_eq("halt_set", {31'd0, halt}, 32'd1);
        check_eq("halt_stall", {31'd0, stall}, 32'd1);
        syscall = 1'b0;
        @(negedge clk);
        #1 check_eq("halt_stall_nosys", {31'd0, stall}, 32'd1);
        v0 = 32'd11;
        a0 = 32'h55;
        syscall = 1'b1;
        repeat (10) @(negedge clk);
        syscall = 1'b0;
        #1;
        check_eq("halt_ignores_sys", got_q.size(), 0);
        check_eq("halt_sticky", {31'd0, halt}, 32'd1);
        reset = 1'b1;
        #1;
        check_eq("halt_cleared", {31'd0, halt}, 32'd0);
        check_eq("halt_stall_cleared", {31'd0, stall}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
